// File: rtl/dsram_arb.sv
// Data SRAM arbiter: pipeline load/store port has priority, the DMA/debug port
// is guaranteed a slot after STARVE_MAX consecutive lost cycles.
module dsram_arb #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stallreq,

    input  logic        dma_req,
    input  logic [3:0]  dma_wen,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,

    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;
    logic             rd_dma;
    logic             force_gnt;
    logic             dma_win;
    logic             cpu_win;

    // Every combinational output is qualified by rst so the block is silent
    // for the whole time reset is held low, not just from the next edge.
    always_comb begin
        force_gnt       = (starve_cnt == CNT_MAX);
        dma_win         = rst && dma_req && (!cpu_en || force_gnt);
        cpu_win         = rst && cpu_en && !(dma_req && force_gnt);

        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        if (dma_win) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = dma_wen;
            data_sram_addr  = dma_addr;
            data_sram_wdata = dma_wdata;
        end else if (cpu_win) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = cpu_wen;
            data_sram_addr  = cpu_addr;
            data_sram_wdata = cpu_wdata;
        end

        dma_gnt      = dma_win;
        cpu_stallreq = cpu_en && dma_win;

        starve_cnt_nxt = starve_cnt;
        if (!dma_req || dma_win) begin
            starve_cnt_nxt = '0;
        end else if (cpu_win && (starve_cnt != CNT_MAX)) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            rd_dma     <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            rd_dma     <= dma_win && (dma_wen == 4'b0000);
        end
    end

    assign dma_rvalid = rd_dma;
    assign cpu_rdata  = rst ? data_sram_rdata : '0;
    assign dma_rdata  = rst ? data_sram_rdata : '0;

endmodule

// File: tb/tb_dsram_arb.sv
// Self-checking bench for dsram_arb: directed scenarios plus constrained random
// traffic compared against a cycle-level behavioural model of the arbiter.
module tb_dsram_arb;

    localparam int SM = 4;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stallreq;
    logic        dma_req;
    logic [3:0]  dma_wen;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    int checks = 0;
    int errors = 0;

    dsram_arb #(.STARVE_MAX(SM), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stallreq(cpu_stallreq),
        .dma_req(dma_req), .dma_wen(dma_wen), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM device driven only by the DUT's SRAM-side outputs.
    logic [31:0] sram_mem [256];
    always @(posedge clk) begin
        if (data_sram_en) begin
            if (data_sram_wen == 4'b0000)
                data_sram_rdata <= sram_mem[data_sram_addr[9:2]];
            else
                for (int b = 0; b < 4; b++)
                    if (data_sram_wen[b]) sram_mem[data_sram_addr[9:2]][b*8 +: 8] <= data_sram_wdata[b*8 +: 8];
        end
    end

    // Reference model state: memory image, consecutive DMA losses, pending read results.
    logic [31:0] ref_mem [256];
    int          lost;
    bit          exp_rvalid;
    logic [31:0] exp_dma_rd;
    bit          exp_cpu_rd_v;
    logic [31:0] exp_cpu_rd;
    bit          m_dwin;
    bit          m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {31'd0, dma_gnt}, 32'd0);
        chk({tag, "_stall"}, {31'd0, cpu_stallreq}, 32'd0);
        chk({tag, "_en"}, {31'd0, data_sram_en}, 32'd0);
        chk({tag, "_wen"}, {28'd0, data_sram_wen}, 32'd0);
        chk({tag, "_addr"}, data_sram_addr, 32'd0);
        chk({tag, "_wdata"}, data_sram_wdata, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, dma_rvalid}, 32'd0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_dma_rdata"}, dma_rdata, 32'd0);
    endtask

    // One arbitration cycle, entered just after a falling edge.
    task automatic step(input bit ce, input logic [3:0] cw, input logic [31:0] ca, input logic [31:0] cd,
                        input bit dr, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                        input bit mid_rst);
        bit          dwin, cwin;
        bit          e_en;
        logic [3:0]  e_wen;
        logic [31:0] e_addr, e_wdata;
        logic [7:0]  idx;

        cpu_en = ce; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_wen = dw; dma_addr = da; dma_wdata = dd;

        dwin = dr && (!ce || lost == SM);
        cwin = ce && !dwin;
        e_en = dwin || cwin;
        e_wen = dwin ? dw : (cwin ? cw : 4'd0);
        e_addr = dwin ? da : (cwin ? ca : 32'd0);
        e_wdata = dwin ? dd : (cwin ? cd : 32'd0);
        m_dwin = dwin;
        m_stall = ce && dwin;

        #1;
        chk("dma_gnt", {31'd0, dma_gnt}, {31'd0, dwin});
        chk("cpu_stallreq", {31'd0, cpu_stallreq}, {31'd0, m_stall});
        chk("sram_en", {31'd0, data_sram_en}, {31'd0, e_en});
        chk("sram_wen", {28'd0, data_sram_wen}, {28'd0, e_wen});
        chk("sram_addr", data_sram_addr, e_addr);
        chk("sram_wdata", data_sram_wdata, e_wdata);

        if (mid_rst) begin
            rst = 1'b0;
            #1;
            chk_all_zero("midrst");
            lost = 0;
            exp_rvalid = 1'b0;
            exp_cpu_rd_v = 1'b0;
            m_dwin = 1'b0;
            m_stall = 1'b0;
            @(posedge clk); #1;
            chk("midrst_rvalid_after_edge", {31'd0, dma_rvalid}, 32'd0);
            @(negedge clk);
            rst = 1'b1;
            return;
        end

        @(posedge clk); #1;
        idx = e_addr[9:2];
        exp_rvalid = dwin && (dw == 4'd0);
        exp_cpu_rd_v = cwin && (cw == 4'd0);
        if (e_en && e_wen == 4'd0) begin
            exp_dma_rd = ref_mem[idx];
            exp_cpu_rd = ref_mem[idx];
        end else if (e_en) begin
            for (int b = 0; b < 4; b++)
                if (e_wen[b]) ref_mem[idx][b*8 +: 8] = e_wdata[b*8 +: 8];
        end
        if (!dr || dwin) lost = 0;
        else if (lost < SM) lost++;

        chk("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, exp_rvalid});
        if (exp_rvalid) chk("dma_rdata", dma_rdata, exp_dma_rd);
        if (exp_cpu_rd_v) chk("cpu_rdata", cpu_rdata, exp_cpu_rd);
        @(negedge clk);
    endtask

    bit          pend;
    bit          last_stall;
    logic [3:0]  r_dw, r_cw;
    logic [31:0] r_da, r_dd, r_ca, r_cd;
    bit          r_ce;

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
            ref_mem[i]  = 32'hA5000000 ^ (i * 32'h00010203);
        end
        lost = 0; exp_rvalid = 1'b0; exp_cpu_rd_v = 1'b0;

        // Reset held with both requesters active: everything silent.
        rst = 1'b0;
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h100; cpu_wdata = 32'h0;
        dma_req = 1'b1; dma_wen = 4'd0; dma_addr = 32'h200; dma_wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Contention straight out of reset: counter starts at 0.
        for (int i = 0; i < SM + 2; i++)
            step(1, 4'd0, 32'h100, 32'h0, 1, 4'd0, 32'h200, 32'h0, 0);
        step(0, 4'd0, 32'h0, 32'h0, 0, 4'd0, 32'h0, 32'h0, 0);

        // Pipeline-only read.
        step(1, 4'd0, 32'h100, 32'h0, 0, 4'd0, 32'h0, 32'h0, 0);
        step(0, 4'd0, 32'h0, 32'h0, 0, 4'd0, 32'h0, 32'h0, 0);

        // DMA-only back-to-back reads.
        step(0, 4'd0, 32'h0, 32'h0, 1, 4'd0, 32'h200, 32'h0, 0);
        step(0, 4'd0, 32'h0, 32'h0, 1, 4'd0, 32'h204, 32'h0, 0);
        step(0, 4'd0, 32'h0, 32'h0, 0, 4'd0, 32'h0, 32'h0, 0);

        // Contention with a DMA write, then read it back via the pipeline.
        for (int i = 0; i < SM + 2; i++)
            step(1, 4'd0, 32'h104, 32'h0, !(i > SM), 4'hF, 32'h300, 32'hDEADBEEF, 0);
        step(1, 4'd0, 32'h300, 32'h0, 0, 4'd0, 32'h0, 32'h0, 0);

        // DMA read under force.
        for (int i = 0; i < SM + 2; i++)
            step(1, 4'hF, 32'h108, 32'h11111111 * i, !(i > SM), 4'd0, 32'h300, 32'h0, 0);

        // Reset dropped between the forced DMA read grant and the next edge.
        for (int i = 0; i < SM; i++)
            step(1, 4'd0, 32'h10C, 32'h0, 1, 4'd0, 32'h304, 32'h0, 0);
        step(1, 4'd0, 32'h10C, 32'h0, 1, 4'd0, 32'h304, 32'h0, 1);
        for (int i = 0; i < SM + 2; i++)
            step(1, 4'd0, 32'h10C, 32'h0, 1, 4'd0, 32'h304, 32'h0, 0);

        // Random traffic obeying both requester protocols.
        pend = 0; last_stall = 0;
        r_ce = 0; r_cw = 0; r_ca = 0; r_cd = 0; r_dw = 0; r_da = 0; r_dd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1;
                r_dw = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
                r_da = {22'd0, 8'($urandom), 2'b00};
                r_dd = $urandom;
            end
            if (!last_stall) begin
                r_ce = ($urandom_range(0, 3) != 0);
                r_cw = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
                r_ca = {22'd0, 8'($urandom), 2'b00};
                r_cd = $urandom;
            end
            step(r_ce, r_cw, r_ca, r_cd, pend, r_dw, r_da, r_dd, 0);
            if (m_dwin) pend = 0;
            last_stall = m_stall;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
